// File: rtl/lc_sram_ctrl.sv
// Card-RAM SRAM responder: CPU strobe requests (1-deep pending latch) and a low-priority DMA req/ack port share one async SRAM.
// Latency: strobe edge to dout_valid is WAIT_CYCLES+3 clocks; DMA is granted only from IDLE with no CPU work waiting.
module lc_sram_ctrl #(
   parameter int WAIT_CYCLES = 2,
   parameter int AW          = 18
) (
   input  logic          mclk28,
   input  logic          reset_n,
   input  logic          strobe,
   input  logic          card_sel,
   input  logic          cpu_we,
   input  logic          card_ram_rd,
   input  logic          card_ram_we,
   input  logic [AW-1:0] ram_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    dout,
   output logic          dout_valid,
   output logic          rom_sel,
   output logic          wp_hit,
   output logic          overrun,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [7:0]    dma_din,
   output logic          dma_ack,
   output logic [7:0]    dma_dout,
   output logic [AW-1:0] sram_addr,
   output logic [7:0]    sram_dq_o,
   output logic          sram_dq_oe,
   input  logic [7:0]    sram_dq_i,
   output logic          sram_ce_n,
   output logic          sram_oe_n,
   output logic          sram_we_n
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   state_t          state;
   logic            strobe_d;
   logic            cpu_edge;
   logic            cpu_rd_req;
   logic            cpu_wr_req;
   logic            cpu_req;
   logic            pend_vld;
   logic            pend_we;
   logic [AW-1:0]   pend_addr;
   logic [7:0]      pend_din;
   logic            work_we;
   logic            work_dma;
   logic [2:0]      wait_cnt;

   assign cpu_edge   = strobe & ~strobe_d & card_sel;
   assign cpu_wr_req = cpu_edge & cpu_we & card_ram_we;
   assign cpu_rd_req = cpu_edge & ~cpu_we & card_ram_rd;
   assign cpu_req    = cpu_wr_req | cpu_rd_req;
   assign rom_sel    = card_sel & ~cpu_we & ~card_ram_rd;

   always_ff @(posedge mclk28 or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         strobe_d   <= 1'b0;
         pend_vld   <= 1'b0;
         pend_we    <= 1'b0;
         pend_addr  <= '0;
         pend_din   <= 8'h00;
         work_we    <= 1'b0;
         work_dma   <= 1'b0;
         wait_cnt   <= 3'd0;
         sram_addr  <= '0;
         sram_dq_o  <= 8'h00;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         dout       <= 8'h00;
         dma_dout   <= 8'h00;
         dout_valid <= 1'b0;
         wp_hit     <= 1'b0;
         dma_ack    <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         strobe_d   <= strobe;
         dout_valid <= 1'b0;
         wp_hit     <= 1'b0;
         dma_ack    <= 1'b0;

         case (state)
            IDLE: begin
               if (pend_vld) begin
                  pend_vld   <= 1'b0;
                  work_we    <= pend_we;
                  work_dma   <= 1'b0;
                  sram_addr  <= pend_addr;
                  sram_dq_o  <= pend_din;
                  sram_dq_oe <= pend_we;
                  sram_ce_n  <= 1'b0;
                  state      <= SETUP;
               end else if (dma_req && !cpu_req) begin
                  // a CPU edge in this very cycle reaches pending next cycle and must still win
                  work_we    <= dma_we;
                  work_dma   <= 1'b1;
                  sram_addr  <= dma_addr;
                  sram_dq_o  <= dma_din;
                  sram_dq_oe <= dma_we;
                  sram_ce_n  <= 1'b0;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               wait_cnt  <= 3'd0;
               sram_we_n <= ~work_we;
               sram_oe_n <= work_we;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (wait_cnt == 3'(WAIT_CYCLES - 1)) begin
                  sram_oe_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  if (work_dma) begin
                     dma_ack <= 1'b1;
                     if (!work_we) dma_dout <= sram_dq_i;
                  end else if (!work_we) begin
                     dout       <= sram_dq_i;
                     dout_valid <= 1'b1;
                  end
                  state <= HOLD;
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            HOLD: begin
               sram_ce_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // capture after the FSM so a new request overrides the IDLE clear of pending
         if (cpu_edge && cpu_we && !card_ram_we) wp_hit <= 1'b1;
         if (cpu_req) begin
            if (pend_vld && state != IDLE) overrun <= 1'b1;
            pend_vld  <= 1'b1;
            pend_we   <= cpu_wr_req;
            pend_addr <= ram_addr;
            pend_din  <= cpu_din;
         end
      end
   end

endmodule
